// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the peripheral register bus: round-robin with a
// bounded lock so one master can finish short read-modify-write sequences.
module periph_bus_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] WD,
  output logic              WE,
  input  logic [DATA_W-1:0] RD,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t     state;
  logic       lock_active;
  logic [7:0] lock_cnt;

  logic              req_own;
  logic              req_oth;
  logic              win;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Winner of the IDLE arbitration; 'owner' doubles as the last-granted master.
  always_comb begin
    // NOTE: every signal gets a value on every path so no latch is inferred.
    req_own = owner ? m1_req : m0_req;
    req_oth = owner ? m0_req : m1_req;
    if (lock_active && req_own && !(lock_cnt == LOCK_MAX && req_oth))
      win = owner;
    else if (m0_req && m1_req)
      win = ~owner;
    else
      win = m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_lock  = win ? m1_lock  : m0_lock;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below reads the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b1;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      A           <= '0;
      WD          <= '0;
      WE          <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner       <= win;
            A           <= sel_addr;
            WD          <= sel_wdata;
            WE          <= sel_we;
            lock_active <= sel_lock;
            // Count saturates so an uncontested locked master keeps the bus.
            if (win == owner && lock_active)
              lock_cnt <= (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 8'd1;
            else
              lock_cnt <= 8'd1;
            state <= XFER;
          end else begin
            A  <= '0;
            WD <= '0;
            WE <= 1'b0;
          end
        end
        XFER: begin
          // Read data is captured for writes too; the write commits on this edge.
          if (owner) begin
            m1_rdata <= RD;
            m1_ack   <= 1'b1;
          end else begin
            m0_rdata <= RD;
            m0_ack   <= 1'b1;
          end
          WE    <= 1'b0;
          state <= ACK;
        end
        ACK: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          A      <= '0;
          WD     <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_periph_bus_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int ML = 3;

  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr, A;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, WD, RD;
  logic          m0_ack, m1_ack, WE, busy, owner;

  periph_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .A(A), .WD(WD), .WE(WE), .RD(RD), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Peripheral register file, written only from the edge helper below.
  logic [DW-1:0] per_mem [32];
  assign RD = per_mem[A];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-master pending transactions; the head drives the master's pins.
  txn_t q0[$];
  txn_t q1[$];
  int   ack_log[$];
  int   cyc;

  // Reference model: transaction phases, last owner, lock state, memory image.
  int            ph;
  logic          own, lk_on, cur_m;
  int            lk_n;
  txn_t          cur;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_rd0, exp_rd1, exp_wd;
  logic [AW-1:0] exp_a;
  logic          exp_we, exp_ack0, exp_ack1;

  task automatic drive();
    txn_t t0, t1;
    t0 = (q0.size() > 0) ? q0[0] : '0;
    t1 = (q1.size() > 0) ? q1[0] : '0;
    m0_req = (q0.size() > 0); m0_we = t0.we; m0_lock = t0.lock;
    m0_addr = t0.addr; m0_wdata = t0.wdata;
    m1_req = (q1.size() > 0); m1_we = t1.we; m1_lock = t1.lock;
    m1_addr = t1.addr; m1_wdata = t1.wdata;
  endtask

  task automatic model_reset();
    ph = 0; own = 1'b1; lk_on = 1'b0; lk_n = 0; cur_m = 1'b0; cur = '0;
    exp_a = '0; exp_wd = '0; exp_we = 1'b0; exp_ack0 = 1'b0; exp_ack1 = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;
  endtask

  task automatic model_edge();
    logic r0, r1, rown, roth, w;
    r0 = (q0.size() > 0);
    r1 = (q1.size() > 0);
    case (ph)
      0: if (r0 || r1) begin
        rown = own ? r1 : r0;
        roth = own ? r0 : r1;
        if (lk_on && rown && !(lk_n == ML && roth)) w = own;
        else if (r0 && r1)                         w = !own;
        else                                       w = r1;
        if (w == own && lk_on) lk_n = (lk_n < ML) ? lk_n + 1 : ML;
        else                   lk_n = 1;
        cur = w ? q1[0] : q0[0];
        cur_m = w; own = w; lk_on = cur.lock;
        exp_a = cur.addr; exp_wd = cur.wdata; exp_we = cur.we;
        ph = 1;
      end
      1: begin
        if (cur_m) begin exp_rd1 = ref_mem[cur.addr]; exp_ack1 = 1'b1; end
        else       begin exp_rd0 = ref_mem[cur.addr]; exp_ack0 = 1'b1; end
        if (cur.we) ref_mem[cur.addr] = cur.wdata;
        exp_we = 1'b0;
        ph = 2;
      end
      default: begin
        exp_ack0 = 1'b0; exp_ack1 = 1'b0; exp_a = '0; exp_wd = '0;
        ph = 0;
      end
    endcase
  endtask

  task automatic compare();
    check("A",        32'(A),        32'(exp_a));
    check("WD",       WD,            exp_wd);
    check("WE",       32'(WE),       32'(exp_we));
    check("m0_ack",   32'(m0_ack),   32'(exp_ack0));
    check("m1_ack",   32'(m1_ack),   32'(exp_ack1));
    check("m0_rdata", m0_rdata,      exp_rd0);
    check("m1_rdata", m1_rdata,      exp_rd1);
    check("busy",     32'(busy),     32'(ph != 0));
    check("owner",    32'(owner),    32'(own));
  endtask

  // One rising edge; the peripheral write lands just after it so RD is
  // sampled by the DUT with the pre-edge contents.
  task automatic clk_edge();
    logic          do_wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    do_wr = WE; wa = A; wd = WD;
    @(posedge clk);
    #1;
    if (do_wr) per_mem[wa] = wd;
  endtask

  task automatic tick();
    model_edge();
    clk_edge();
    @(negedge clk);
    cyc++;
    compare();
    if (exp_ack0) begin ack_log.push_back(0); void'(q0.pop_front()); end
    if (exp_ack1) begin ack_log.push_back(1); void'(q1.pop_front()); end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete(); ack_log.delete();
    drive();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 1;
  endtask

  function automatic txn_t mk(input logic we, input logic lock, input int addr, input logic [DW-1:0] wdata);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = AW'(addr); t.wdata = wdata;
    return t;
  endfunction

  task automatic run_acks(input int n, input string tag);
    int budget;
    budget = 0;
    while (ack_log.size() < n && budget < 200) begin
      tick();
      budget++;
    end
    check({tag, "_acks"}, 32'(ack_log.size()), 32'(n));
  endtask

  initial begin
    int we_cnt, a8_cyc, a12_cyc, idle_cnt, ack_c0, ack_c1;
    logic [DW-1:0] saved;
    int exp_t3 [8];

    for (int i = 0; i < 32; i++) begin
      per_mem[i] = $urandom;
      ref_mem[i] = per_mem[i];
    end
    model_reset();
    drive();
    @(negedge clk);
    compare();
    do_reset();

    // Single write then read from m0.
    q0.push_back(mk(1'b1, 1'b0, 4, 32'h0000_00A5));
    q0.push_back(mk(1'b0, 1'b0, 4, 32'h0));
    drive();
    we_cnt = 0; ack_c0 = 0; ack_c1 = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (WE) we_cnt++;
      if (m0_ack && ack_c0 == 0)      ack_c0 = cyc;
      else if (m0_ack && ack_c1 == 0) ack_c1 = cyc;
    end
    check("t1_we_cycles", 32'(we_cnt), 32'd1);
    check("t1_ack_cyc_a", 32'(ack_c0), 32'd3);
    check("t1_ack_cyc_b", 32'(ack_c1), 32'd6);
    check("t1_rdata", m0_rdata, 32'h0000_00A5);
    check("t1_m1_rdata", m1_rdata, 32'h0);

    // Simultaneous requests alternate starting with m0.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(1'b0, 1'b0, int'($urandom_range(31)), $urandom));
      q1.push_back(mk(1'b0, 1'b0, int'($urandom_range(31)), $urandom));
    end
    drive();
    run_acks(4, "t2");
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check($sformatf("t2_grant%0d", i), 32'(ack_log[i]), 32'(i % 2));

    // Locked m0 against a continuously requesting m1.
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back(mk(1'b0, 1'b1, i, 32'h0));
    for (int i = 0; i < 2; i++) q1.push_back(mk(1'b1, 1'b0, 16 + i, $urandom));
    drive();
    exp_t3 = '{0, 0, 0, 1, 0, 0, 0, 1};
    run_acks(8, "t3");
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      check($sformatf("t3_grant%0d", i), 32'(ack_log[i]), 32'(exp_t3[i]));

    // Locked m0 with m1 idle, then m1 joins during the tenth ack.
    do_reset();
    for (int i = 0; i < 11; i++) q0.push_back(mk(1'b0, 1'b1, i, 32'h0));
    drive();
    run_acks(10, "t4a");
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      check($sformatf("t4_grant%0d", i), 32'(ack_log[i]), 32'd0);
    q1.push_back(mk(1'b0, 1'b0, 20, 32'h0));
    drive();
    run_acks(12, "t4b");
    if (ack_log.size() >= 12) begin
      check("t4_m1_wins", 32'(ack_log[10]), 32'd1);
      check("t4_m0_after", 32'(ack_log[11]), 32'd0);
    end

    // Reset asserted while m1's write is on the bus.
    do_reset();
    q1.push_back(mk(1'b1, 1'b0, 4, 32'h0000_FFFF));
    drive();
    saved = per_mem[4];
    tick();
    check("t5_we_xfer", 32'(WE), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_we_async", 32'(WE), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    q1.delete();
    drive();
    model_reset();
    clk_edge();
    @(negedge clk);
    check("t5_mem", per_mem[4], saved);
    check("t5_no_ack", 32'(m1_ack), 32'd0);
    check("t5_owner", 32'(owner), 32'd1);
    compare();
    rst_n = 1'b1;
    cyc = 1;

    // Back-to-back accesses from m1 with the address changed in its ack cycle.
    do_reset();
    q1.push_back(mk(1'b0, 1'b0, 8, 32'h0));
    q1.push_back(mk(1'b0, 1'b0, 12, 32'h0));
    drive();
    a8_cyc = 0; a12_cyc = 0; idle_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (A == 5'd8 && a8_cyc == 0)   a8_cyc = cyc;
      if (A == 5'd12 && a12_cyc == 0) a12_cyc = cyc;
      if (a8_cyc != 0 && a12_cyc == 0 && !busy) idle_cnt++;
    end
    check("t6_a8_seen", 32'(a8_cyc != 0), 32'd1);
    check("t6_spacing", 32'(a12_cyc - a8_cyc), 32'd3);
    check("t6_idle_gap", 32'(idle_cnt), 32'd1);

    // Random traffic: bursts of queued accesses with random lock/we/addr/data.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() == 0 && $urandom_range(3) == 0) begin
        int n = int'($urandom_range(1, 4));
        for (int k = 0; k < n; k++)
          q0.push_back(mk(1'($urandom), 1'($urandom), int'($urandom_range(31)), $urandom));
      end
      if (q1.size() == 0 && $urandom_range(3) == 0) begin
        int n = int'($urandom_range(1, 4));
        for (int k = 0; k < n; k++)
          q1.push_back(mk(1'($urandom), 1'($urandom), int'($urandom_range(31)), $urandom));
      end
      drive();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single peripheral register bus (A/WD/WE/RD) between two masters: m0 (CPU load/store path) and m1 (a secondary master, e.g. boot loader or debug port).
- Arbitrates round-robin with an optional bounded lock, so one master can complete short read-modify-write sequences.
- Sits between the masters and the peripherals block. Exactly one access is on the bus at a time.

Parameters:
ADDR_W, 5, peripheral word-address width
DATA_W, 32, data width
MAX_LOCK, 8, max consecutive locked grants to one master while the other is requesting (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
m0_req  in  1  master 0 access request; held until m0_ack
m0_we  in  1  master 0 write enable (1 = write, 0 = read)
m0_lock  in  1  master 0 requests to keep priority for its next access
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ack  out  1  one-cycle completion pulse to master 0
m0_rdata  out  DATA_W  read data for master 0, valid while m0_ack=1, held afterwards
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_* for master 1
A  out  ADDR_W  peripheral address
WD  out  DATA_W  peripheral write data
WE  out  1  peripheral write enable
RD  in  DATA_W  peripheral read data, combinational from A
busy  out  1  high in XFER and ACK states
owner  out  1  index of current or last granted master

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; A=0, WD=0, WE=0; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; busy=0.
  - owner=1 (last_owner), so m0 wins the first tie. lock_active=0, lock_cnt=0.
  - Reset asserted during XFER drops WE immediately. No write commits and no ack is issued.
- States are IDLE, XFER and ACK. All outputs are registered except busy, which is decoded from state.
- IDLE:
  - Requests are sampled only in IDLE. With no req, stay in IDLE with A/WD/WE=0.
  - With any req, pick winner w:
    - If lock_active, req[owner]=1 and NOT (lock_cnt==MAX_LOCK and req[other]=1): w=owner.
    - Else if both req: w=!owner.
    - Else: w=the requester.
  - On the edge: owner<=w; A<=addr_w; WD<=wdata_w; WE<=we_w; state<=XFER.
  - Lock update when w==old owner and lock_active: lock_cnt<=lock_cnt+1.
  - Lock update otherwise: lock_cnt<=1.
  - In all cases lock_active<=lock_w. If the lock was forced off by MAX_LOCK, lock_cnt restarts at 1 for the new owner.
- XFER (1 cycle):
  - A/WD/WE are stable on the bus. A peripheral write commits at the XFER->ACK edge.
  - At that edge: rdata_owner<=RD (captured for writes too); ack_owner<=1; WE<=0; A and WD hold; state<=ACK.
  - The non-owner's rdata is unchanged.
- ACK (1 cycle):
  - ack_owner=1 and all requests are ignored.
  - At the next edge: ack<=0; A<=0; WD<=0; state<=IDLE.
- Master protocol:
  - req and its qualifiers stay stable from assertion until the cycle ack=1.
  - A master may keep req high after ack with new addr/data/we to issue its next access; it is sampled in the following IDLE.
- Access latency is 3 cycles (IDLE sample -> XFER -> ACK), so at most one access per 3 cycles.
- Lock without competition: with m1 idle, m0 locked keeps the grant indefinitely; lock_cnt saturates at MAX_LOCK.
- Dropping lock: a locked master dropping lock on its next request clears lock_active at that grant.
- Non-owner lock: a lock from the non-owner has no effect until that master is granted.

Test Plan:
- Single write then read: m0 writes addr=4, wdata=0x000A5 (bench RD model = 32-entry reg file), then reads addr=4.
  - -> WE=1 for exactly 1 cycle in XFER.
  - -> m0_ack pulses on cycles 3 and 6 from the first req.
  - -> m0_rdata=0x000A5. m1_rdata stays 0.
- Simultaneous request after reset: m0 and m1 both req.
  - -> m0 granted first (owner=0), m1 next, then alternating.
  - -> Pattern m0,m1,m0,m1 over 4 accesses with both held high.
- Lock fairness, MAX_LOCK=3: m0 req with lock=1 continuously, m1 req continuously.
  - -> grants m0,m0,m0,m1,m0,m0,m0,m1.
  - -> No m1 starvation beyond 3 m0 accesses.
- Lock with idle competitor: m0 locked for 10 accesses, m1 idle.
  - -> 10 consecutive m0 grants.
  - -> m1 req asserted at access 10 is granted at the next arbitration after lock_cnt reaches MAX_LOCK.
- Reset mid-XFER: assert rst_n=0 while in XFER with m1 writing 0xFFFF to addr=4.
  - -> WE falls asynchronously; bench reg[4] unchanged.
  - -> No m1_ack; state IDLE; owner=1.
- Back-to-back from one master: m1 holds req and changes addr 8->12 in its ack cycle.
  - -> Second access appears on A=12 exactly 3 cycles after the first (A=8).
  - -> busy low for exactly one cycle between the accesses.
